// File: rtl/ssp_fifo_sched.sv
// Shares one FIFO port pair between NREQ round-robin producers and one consumer.
// FIFO reads and writes never overlap; contention alternates via a priority bit.
// Read data returns a cycle after read_en and is re-timed through a 2-entry buffer.
module ssp_fifo_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 28,
  parameter int unsigned IW   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [IW-1:0]      grant_id,
  output logic [DW-1:0]      fifo_data_in,
  output logic               fifo_write_en,
  input  logic               fifo_full,
  output logic               fifo_read_en,
  input  logic               fifo_empty,
  input  logic [DW-1:0]      fifo_data_out,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  input  logic               out_ready
);

  typedef enum logic {PrioWrite, PrioRead} prio_e;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  prio_e         prio_q, prio_d;
  logic [1:0]    occ_q, occ_d;
  logic [1:0]    occ_after_pop;
  logic          inflight_q;
  logic [DW-1:0] buf0_q, buf1_q;  // buf0_q is always the head entry

  logic [IW-1:0] winner;
  logic [IW-1:0] idx;
  logic [DW-1:0] win_data;
  logic          want_wr, want_rd, do_wr, do_rd;
  logic          pop, push;
  logic [2:0]    committed;

  assign out_valid     = (occ_q != 2'd0);
  assign out_data      = buf0_q;
  assign pop           = out_valid & out_ready;
  assign push          = inflight_q;
  assign occ_after_pop = occ_q - {1'b0, pop};

  // Round-robin search from rr_ptr upward; first requester found wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      // Descending offset so the smallest offset is assigned last and wins.
      idx = IW'((32'(rr_ptr_q) + k - 1) % NREQ);
      if (req_valid[idx]) winner = idx;
    end
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == IW'(i)) win_data = req_data[i*DW +: DW];
    end
  end

  // Scheduler: contested cycles go to the op named by prio, which then flips.
  always_comb begin
    committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    want_wr   = (|req_valid) & ~fifo_full;
    want_rd   = ~fifo_empty & (committed < 3'd2);
    do_wr     = want_wr & (~want_rd | (prio_q == PrioWrite));
    do_rd     = want_rd & (~want_wr | (prio_q == PrioRead));
    prio_d    = prio_q;
    if (want_wr && want_rd) prio_d = (prio_q == PrioWrite) ? PrioRead : PrioWrite;
    rr_ptr_d  = rr_ptr_q;
    if (do_wr) rr_ptr_d = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
    occ_d     = occ_q + {1'b0, push} - {1'b0, pop};
  end

  // FIFO-side outputs, forced idle while reset is asserted.
  always_comb begin
    fifo_write_en = reset & do_wr;
    fifo_read_en  = reset & do_rd;
    req_ready     = '0;
    grant_id      = '0;
    fifo_data_in  = '0;
    if (fifo_write_en) begin
      req_ready[winner] = 1'b1;
      grant_id          = winner;
      fifo_data_in      = win_data;
    end
  end

  // State update: arbiter pointer, priority, read pipeline and output buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      prio_q     <= PrioWrite;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      prio_q     <= prio_d;
      occ_q      <= occ_d;
      inflight_q <= do_rd;
      // Popping a full buffer shifts the second entry to the head; popping the
      // last entry leaves the head untouched so out_data holds its value.
      if (pop && occ_q == 2'd2) buf0_q <= buf1_q;
      if (push) begin
        if (occ_after_pop == 2'd0) buf0_q <= fifo_data_out;
        else                       buf1_q <= fifo_data_out;
      end
    end
  end

endmodule

// File: tb/tb_ssp_fifo_sched.sv
// Bench for ssp_fifo_sched: behavioural 8-deep FIFO, queue-based reference
// model compared every cycle, plus directed literal checks and random traffic.
module tb_ssp_fifo_sched;

  localparam int NREQ = 4;
  localparam int DW   = 28;
  localparam int IW   = 2;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [IW-1:0]      grant_id;
  logic [DW-1:0]      fifo_data_in;
  logic               fifo_write_en;
  logic               fifo_full;
  logic               fifo_read_en;
  logic               fifo_empty;
  logic [DW-1:0]      fifo_data_out;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic               out_ready;

  ssp_fifo_sched #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .grant_id     (grant_id),
    .fifo_data_in (fifo_data_in),
    .fifo_write_en(fifo_write_en),
    .fifo_full    (fifo_full),
    .fifo_read_en (fifo_read_en),
    .fifo_empty   (fifo_empty),
    .fifo_data_out(fifo_data_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: registered data_out, same synchronous reset.
  logic [DW-1:0] fmem [8];
  int            fwp, frp, fcnt;
  assign fifo_full  = (fcnt == 8);
  assign fifo_empty = (fcnt == 0);
  always @(posedge clk) begin
    if (!reset) begin
      fwp <= 0; frp <= 0; fcnt <= 0; fifo_data_out <= '0;
    end else begin
      if (fifo_write_en && fcnt < 8) begin
        fmem[fwp] <= fifo_data_in;
        fwp       <= (fwp + 1) % 8;
      end
      if (fifo_read_en && fcnt > 0) begin
        fifo_data_out <= fmem[frp];
        frp           <= (frp + 1) % 8;
      end
      fcnt <= fcnt + ((fifo_write_en && fcnt < 8) ? 1 : 0) - ((fifo_read_en && fcnt > 0) ? 1 : 0);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int            m_rr;
  bit            m_prio_wr;
  bit            m_inflight;
  logic [DW-1:0] m_pend;
  logic [DW-1:0] m_obuf[$];
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_last;
  logic [DW-1:0] sb[$];
  bit            m_in_reset = 1'b0;
  int            m_nwr;

  // Observations of the DUT, recorded for directed checks
  int            cyc = 0;
  bit            obs_wr, obs_rd, obs_valid, obs_xfer;
  int            obs_gid;
  logic [DW-1:0] obs_data;
  int            n_xfer;

  // Model temporaries
  bit            t_pop, t_ww, t_wr, t_dw, t_dr;
  int            t_eff, t_w;
  logic [DW-1:0] t_exp_data, t_wdata;
  logic [NREQ-1:0] t_onehot;

  task automatic cycle();
    @(negedge clk);
    cyc++;
    obs_wr    = fifo_write_en;
    obs_rd    = fifo_read_en;
    obs_gid   = int'(grant_id);
    obs_valid = out_valid;
    obs_xfer  = out_valid && out_ready;
    obs_data  = out_data;
    chk("wr_rd_exclusive", 64'(fifo_write_en & fifo_read_en), 64'd0);
    chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
    if (!reset) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_write_en", 64'(fifo_write_en), 64'd0);
      chk("rst_read_en", 64'(fifo_read_en), 64'd0);
      if (m_in_reset) begin
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
      end
      m_rr = 0; m_prio_wr = 1'b1; m_inflight = 1'b0; m_last = '0;
      m_obuf.delete(); m_fifo.delete(); sb.delete();
      m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      t_pop = (m_obuf.size() > 0) && out_ready;
      t_ww  = (req_valid != '0) && (m_fifo.size() < 8);
      t_eff = m_obuf.size() + int'(m_inflight) - int'(t_pop);
      t_wr  = (m_fifo.size() > 0) && (t_eff < 2);
      t_w   = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[(m_rr + k) % NREQ]) begin
          t_w = (m_rr + k) % NREQ;
          break;
        end
      end
      t_dw = t_ww && (!t_wr || m_prio_wr);
      t_dr = t_wr && (!t_ww || !m_prio_wr);
      t_onehot = '0;
      if (t_dw) t_onehot[t_w] = 1'b1;
      t_wdata = req_data[t_w*DW +: DW];
      t_exp_data = (m_obuf.size() > 0) ? m_obuf[0] : m_last;
      chk("out_valid", 64'(out_valid), 64'(m_obuf.size() > 0));
      chk("out_data", 64'(out_data), 64'(t_exp_data));
      chk("write_en", 64'(fifo_write_en), 64'(t_dw));
      chk("read_en", 64'(fifo_read_en), 64'(t_dr));
      chk("req_ready", 64'(req_ready), 64'(t_onehot));
      if (t_dw) begin
        chk("grant_id", 64'(grant_id), 64'(t_w));
        chk("fifo_data_in", 64'(fifo_data_in), 64'(t_wdata));
      end else begin
        chk("fifo_data_in_idle", 64'(fifo_data_in), 64'd0);
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else chk("sb_order", 64'(out_data), 64'(sb.pop_front()));
      end
      // Advance model
      if (t_pop) m_last = m_obuf.pop_front();
      if (m_inflight) m_obuf.push_back(m_pend);
      m_inflight = t_dr;
      if (t_dr) m_pend = m_fifo.pop_front();
      if (t_dw) begin
        m_fifo.push_back(t_wdata);
        sb.push_back(t_wdata);
        m_rr = (t_w + 1) % NREQ;
        m_nwr++;
      end
      if (t_ww && t_wr) m_prio_wr = !m_prio_wr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b1;
  endtask

  int gq[$];
  int exp_g[8];
  int nwr, nrd, budget, wcyc, rcyc, vcyc, xfers, viol, prev_op, op;
  logic [DW-1:0] vdata;
  bit p_valid, p_ready;
  logic [DW-1:0] p_data;

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;

    // Reset with all requesters active
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(i + 1);
    do_reset(3);

    // Round robin: first grant to 0, then 0,1,2,3,0 and with 1010: 1,3,1
    gq.delete();
    budget = 0;
    while (gq.size() < 5 && budget < 50) begin
      cycle(); budget++;
      if (obs_wr) gq.push_back(obs_gid);
    end
    req_valid = 4'b1010;
    while (gq.size() < 8 && budget < 100) begin
      cycle(); budget++;
      if (obs_wr) gq.push_back(obs_gid);
    end
    if (gq.size() < 8) chk("rr_timeout", 64'(gq.size()), 64'd8);
    else begin
      exp_g = '{0, 1, 2, 3, 0, 1, 3, 1};
      for (int i = 0; i < 8; i++) chk($sformatf("rr_grant_%0d", i), 64'(gq[i]), 64'(exp_g[i]));
    end

    // Full stall: single requester, consumer stalled
    req_valid = '0;
    do_reset(2);
    out_ready = 1'b0; req_valid = 4'b0001;
    nwr = 0; nrd = 0;
    for (int i = 0; i < 30; i++) begin
      rand_data();
      cycle();
      nwr += int'(obs_wr); nrd += int'(obs_rd);
    end
    chk("full_accept_count", 64'(nwr), 64'd10);
    chk("full_read_count", 64'(nrd), 64'd2);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    // Pointer held at 1 while full: first grant after release must be 1
    req_valid = 4'b1111; out_ready = 1'b1;
    budget = 0; obs_wr = 1'b0;
    while (!obs_wr && budget < 20) begin cycle(); budget++; end
    chk("full_rr_held", 64'(obs_wr ? obs_gid : -1), 64'd1);

    // Latency and order of a single word
    req_valid = '0;
    do_reset(2);
    out_ready = 1'b1;
    cycle();
    req_valid = 4'b0100; req_data[2*DW +: DW] = 28'hABCDEF1;
    cycle();
    chk("lat_write", 64'(obs_wr), 64'd1);
    wcyc = cyc; rcyc = -1; vcyc = -1; xfers = 0; vdata = '0;
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_rd && rcyc < 0) rcyc = cyc;
      if (obs_valid && vcyc < 0) begin vcyc = cyc; vdata = obs_data; end
      xfers += int'(obs_xfer);
    end
    chk("lat_read_after_write", 64'(rcyc - wcyc), 64'd1);
    chk("lat_valid_after_read", 64'(vcyc - rcyc), 64'd2);
    chk("lat_data", 64'(vdata), 64'h0ABCDEF1);
    chk("lat_xfers", 64'(xfers), 64'd1);

    // Contention: every requester valid, consumer always ready
    do_reset(2);
    req_valid = 4'b1111; out_ready = 1'b1;
    m_nwr = 0; n_xfer = 0; viol = 0; prev_op = 0;
    for (int i = 0; i < 40; i++) begin
      rand_data();
      cycle();
      op = obs_wr ? 1 : (obs_rd ? 2 : 0);
      if (i >= 2 && (op == 0 || op == prev_op)) viol++;
      prev_op = op;
    end
    chk("contention_alternation", 64'(viol), 64'd0);
    req_valid = '0;
    for (int i = 0; i < 20; i++) cycle();
    chk("contention_no_loss", 64'(n_xfer), 64'(m_nwr));

    // Backpressure: 20 words, out_ready toggles every 3 cycles
    do_reset(2);
    m_nwr = 0; n_xfer = 0; budget = 0; p_valid = 1'b0; p_ready = 1'b1; p_data = '0;
    while (n_xfer < 20 && budget < 300) begin
      out_ready = ((budget / 3) % 2) == 1;
      rand_data();
      req_valid = (m_nwr < 20) ? NREQ'($urandom_range(1, 15)) : '0;
      cycle(); budget++;
      if (p_valid && !p_ready) begin
        chk("bp_hold_valid", 64'(obs_valid), 64'd1);
        chk("bp_hold_data", 64'(obs_data), 64'(p_data));
      end
      p_valid = obs_valid; p_ready = out_ready; p_data = obs_data;
    end
    chk("bp_transfers", 64'(n_xfer), 64'd20);

    // Random traffic with occasional mid-operation reset
    req_valid = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
      end else begin
        reset = 1'b1;
      end
      rand_data();
      req_valid = NREQ'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ssp_fifo_sched.md
Name: ssp_fifo_sched

Overview:
- Shares one 28-bit 8-deep FIFO port pair between NREQ producers and a single consumer.
- Write side: round-robin arbiter selecting one producer per cycle onto the FIFO write port.
- Read side: issues FIFO reads and re-times the FIFO's registered data_out into a valid/ready stream through a 2-entry output buffer.
- Never asserts FIFO write and read in the same cycle; the FIFO's combined read/write path is not used. Conflicts are resolved by an alternating-priority scheduler.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- DW, 28, data width; matches FIFO width.
- IW, 2, grant index width; IW = clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- req_valid  in  NREQ  per-requester write request.
- req_data  in  NREQ*DW  requester i data in bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot; bit i high = requester i's word is written this cycle.
- grant_id  out  IW  index of granted requester; valid when fifo_write_en = 1.
- fifo_data_in  out  DW  to FIFO data_in.
- fifo_write_en  out  1  to FIFO write_en.
- fifo_full  in  1  from FIFO full.
- fifo_read_en  out  1  to FIFO read_en.
- fifo_empty  in  1  from FIFO empty.
- fifo_data_out  in  DW  from FIFO data_out; updates one cycle after a read.
- out_valid  out  1  output stream valid.
- out_data  out  DW  output stream data.
- out_ready  in  1  consumer accepts when out_valid & out_ready.

Behaviour:
- Reset (reset = 0 at clk edge):
  - rr_ptr = 0, prio = WRITE, buffer occupancy occ = 0, inflight = 0.
  - out_valid = 0, out_data = 0.
  - fifo_write_en, fifo_read_en and req_ready are all 0 while reset is low.
- Reset mid-operation: any in-flight read is discarded and buffered data is lost. The FIFO is reset by the same signal.
- Write candidate (combinational):
  - want_wr = |req_valid & !fifo_full.
  - winner = first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
- Read candidate: want_rd = !fifo_empty & (occ + inflight - pop) < 2, where pop = out_valid & out_ready.
- Scheduling (combinational, registered prio only):
  - Only want_wr: write. Only want_rd: read.
  - Both: perform the op named by prio, then set prio to the other op.
  - A single uncontested op leaves prio unchanged.
- Write issue:
  - fifo_write_en = 1, fifo_data_in = req_data[winner], req_ready = onehot(winner), grant_id = winner.
  - rr_ptr <= (winner + 1) mod NREQ.
  - With no write, req_ready = 0, fifo_write_en = 0, fifo_data_in = 0, and rr_ptr holds.
- Read issue: fifo_read_en = 1 and inflight <= 1. Otherwise inflight <= 0.
- Capture: when inflight = 1, fifo_data_out is pushed into the buffer tail that edge.
- Read latency: read_en in cycle N, capture at end of N+1, out_valid = 1 in N+2 (zero-occupancy case).
- Output buffer:
  - 2-entry FIFO order; out_data = head entry; out_valid = (occ != 0).
  - Push and pop in the same cycle keep occ unchanged.
  - occ never exceeds 2, guaranteed by the want_rd condition.
  - out_data holds its last value when occ = 0 and does not return to 0 (0 after reset only).
- Boundaries:
  - fifo_full with pending requests: no grant, req_ready = 0, rr_ptr holds.
  - fifo_empty: no read.
  - out_ready low with occ = 2: reads stall, writes continue until full.
  - rr_ptr wraps NREQ-1 -> 0.
  - Sustained contention yields strict write/read alternation; neither side starves.
- Invariants (bench asserts every cycle): fifo_write_en & fifo_read_en == 0; req_ready is one-hot or zero.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with all req_valid = 1 -> req_ready = 0, fifo_write_en = 0, fifo_read_en = 0, out_valid = 0, out_data = 0. Release -> first grant to requester 0.
- Round robin: req_valid = 4'b1111 with constant data 0x0000001..0x0000004, out_ready = 0, FIFO starts empty. Write/read alternation applies while reads are possible. Successive grants follow order 0,1,2,3,0 across write cycles. With 4'b1010, grants alternate 1,3,1.
- Full stall: hold out_ready = 0 and drive 12 writes -> fifo_write_en stops once full, req_ready = 0 while full, rr_ptr unchanged. Exactly 10 words accepted in total: 8 in the FIFO plus 2 in the buffer.
- Latency/order: single write of 0xABCDEF1 into the empty FIFO, out_ready = 1 -> read_en is 1 cycle after the write, out_valid rises 2 cycles after read_en, out_data = 0xABCDEF1, and exactly one transfer occurs.
- Contention: all requesters valid and out_ready = 1 continuously for 40 cycles -> write and read ops strictly alternate, never both in the same cycle. Output sequence equals input order with no loss or duplication.
- Backpressure: toggle out_ready every 3 cycles during streaming of 20 words -> occ never exceeds 2, no data dropped, and out_data is stable while out_valid & !out_ready.
